// File: rtl/eqcmp_floprc.sv
// Decode-stage branch equality comparator with forwarding, plus the clearable D->E register bank.
// Define EQCMP_NE_EN to add the notequal_d output for bne.
module eqcmp_floprc #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5,
   parameter int CTRLW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] srca_d,
   input  logic [WIDTH-1:0] srcb_d,
   input  logic [WIDTH-1:0] aluout_m,
   input  logic             forwarda_d,
   input  logic             forwardb_d,
   output logic             equal_d,
`ifdef EQCMP_NE_EN
   output logic             notequal_d,
`endif
   input  logic [WIDTH-1:0] signimm_d,
   input  logic [REGW-1:0]  rs_d,
   input  logic [REGW-1:0]  rt_d,
   input  logic [REGW-1:0]  rd_d,
   input  logic [CTRLW-1:0] ctrl_d,
   output logic [WIDTH-1:0] srca_e,
   output logic [WIDTH-1:0] srcb_e,
   output logic [WIDTH-1:0] signimm_e,
   output logic [REGW-1:0]  rs_e,
   output logic [REGW-1:0]  rt_e,
   output logic [REGW-1:0]  rd_e,
   output logic [CTRLW-1:0] ctrl_e
);

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;

   assign opa     = forwarda_d ? aluout_m : srca_d;
   assign opb     = forwardb_d ? aluout_m : srcb_d;
   assign equal_d = (opa == opb);

`ifdef EQCMP_NE_EN
   assign notequal_d = ~equal_d;
`endif

   logic [WIDTH-1:0] srca_q;
   logic [WIDTH-1:0] srcb_q;
   logic [WIDTH-1:0] signimm_q;
   logic [REGW-1:0]  rs_q;
   logic [REGW-1:0]  rt_q;
   logic [REGW-1:0]  rd_q;
   logic [CTRLW-1:0] ctrl_q;

   // Raw operands are registered; Execute does its own forwarding.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         srca_q    <= '0;
         srcb_q    <= '0;
         signimm_q <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         ctrl_q    <= '0;
      end else begin
         srca_q    <= srca_d;
         srcb_q    <= srcb_d;
         signimm_q <= signimm_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign srca_e    = srca_q;
   assign srcb_e    = srcb_q;
   assign signimm_e = signimm_q;
   assign rs_e      = rs_q;
   assign rt_e      = rt_q;
   assign rd_e      = rd_q;
   assign ctrl_e    = ctrl_q;

endmodule

// File: tb/tb_eqcmp_floprc.sv
// Directed-vector bench for eqcmp_floprc.
// Covers notequal_d when built with EQCMP_NE_EN.
module tb_eqcmp_floprc;

   logic        clk = 1'b0;
   logic        reset, clear;
   logic [31:0] srca_d, srcb_d, aluout_m, signimm_d;
   logic        forwarda_d, forwardb_d;
   logic        equal_d;
`ifdef EQCMP_NE_EN
   logic        notequal_d;
`endif
   logic [4:0]  rs_d, rt_d, rd_d;
   logic [7:0]  ctrl_d;
   logic [31:0] srca_e, srcb_e, signimm_e;
   logic [4:0]  rs_e, rt_e, rd_e;
   logic [7:0]  ctrl_e;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   eqcmp_floprc dut (
      .clk(clk), .reset(reset), .clear(clear),
      .srca_d(srca_d), .srcb_d(srcb_d), .aluout_m(aluout_m),
      .forwarda_d(forwarda_d), .forwardb_d(forwardb_d),
      .equal_d(equal_d),
`ifdef EQCMP_NE_EN
      .notequal_d(notequal_d),
`endif
      .signimm_d(signimm_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .ctrl_d(ctrl_d),
      .srca_e(srca_e), .srcb_e(srcb_e), .signimm_e(signimm_e),
      .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .ctrl_e(ctrl_e)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_e(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [7:0] ctl);
      chk({tag, ".srca_e"}, srca_e, a);
      chk({tag, ".srcb_e"}, srcb_e, b);
      chk({tag, ".signimm_e"}, signimm_e, imm);
      chk({tag, ".rs_e"}, {27'd0, rs_e}, {27'd0, rs});
      chk({tag, ".rt_e"}, {27'd0, rt_e}, {27'd0, rt});
      chk({tag, ".rd_e"}, {27'd0, rd_e}, {27'd0, rd});
      chk({tag, ".ctrl_e"}, {24'd0, ctrl_e}, {24'd0, ctl});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [7:0] ctl);
      srca_d = a; srcb_d = b; signimm_d = imm;
      rs_d = rs; rt_d = rt; rd_d = rd; ctrl_d = ctl;
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0;
      aluout_m = 32'h0; forwarda_d = 1'b0; forwardb_d = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);
      tick();

      // reset with nonzero inputs
      drive(32'hAAAA5555, 32'hAAAA5555, 32'h13579BDF,
            5'd31, 5'd17, 5'd9, 8'hFF);
      tick();
      chk_e("reset", 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);
      chk("reset.equal_d", {31'd0, equal_d}, 32'd1);
      srcb_d = 32'hAAAA5554;
      #1;
      chk("reset.equal_d_ne", {31'd0, equal_d}, 32'd0);

      // load
      reset = 1'b0;
      drive(32'h12345678, 32'h0BADF00D, 32'hFFFFFFFC,
            5'd5, 5'd6, 5'd7, 8'hA2);
      tick();
      chk_e("load", 32'h12345678, 32'h0BADF00D, 32'hFFFFFFFC,
            5'd5, 5'd6, 5'd7, 8'hA2);

      // hold between edges
      drive(32'h11111111, 32'h22222222, 32'h33333333,
            5'd1, 5'd2, 5'd3, 8'h44);
      #3;
      chk_e("hold", 32'h12345678, 32'h0BADF00D, 32'hFFFFFFFC,
            5'd5, 5'd6, 5'd7, 8'hA2);

      // clear inserts bubble
      clear = 1'b1;
      tick();
      chk_e("clear", 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);

      // reload, then clear and reset together
      clear = 1'b0;
      tick();
      chk_e("reload", 32'h11111111, 32'h22222222, 32'h33333333,
            5'd1, 5'd2, 5'd3, 8'h44);
      clear = 1'b1; reset = 1'b1;
      tick();
      chk_e("clr_rst", 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);

      // resume after reset
      clear = 1'b0; reset = 1'b0;
      drive(32'hCAFEF00D, 32'h00000001, 32'h00007FFF,
            5'd10, 5'd20, 5'd30, 8'h5C);
      tick();
      chk_e("resume", 32'hCAFEF00D, 32'h00000001, 32'h00007FFF,
            5'd10, 5'd20, 5'd30, 8'h5C);

      // comparator direct
      srca_d = 32'hDEADBEEF; srcb_d = 32'hDEADBEEF;
      #1;
      chk("cmp.equal", {31'd0, equal_d}, 32'd1);
      srcb_d = 32'hDEADBEEE;
      #1;
      chk("cmp.lsb_diff", {31'd0, equal_d}, 32'd0);
      srcb_d = 32'h5EADBEEF;
      #1;
      chk("cmp.msb_diff", {31'd0, equal_d}, 32'd0);

      // forwarding A
      srca_d = 32'd1; srcb_d = 32'd9; aluout_m = 32'd9;
      forwarda_d = 1'b1;
      #1;
      chk("fwda.equal", {31'd0, equal_d}, 32'd1);
      tick();
      chk("fwda.srca_e", srca_e, 32'd1);
      chk("fwda.srcb_e", srcb_e, 32'd9);

      // forwarding B only: 3 vs 9
      srca_d = 32'd3; srcb_d = 32'd3;
      forwarda_d = 1'b0; forwardb_d = 1'b1;
      #1;
      chk("fwdb.equal", {31'd0, equal_d}, 32'd0);
      srca_d = 32'd9; srcb_d = 32'd4;
      #1;
      chk("fwdb.match", {31'd0, equal_d}, 32'd1);

      // both forwards
      forwarda_d = 1'b1;
      srca_d = 32'd3; srcb_d = 32'd4;
      #1;
      chk("fwdab.equal", {31'd0, equal_d}, 32'd1);

`ifdef EQCMP_NE_EN
      forwarda_d = 1'b0; forwardb_d = 1'b0;
      srca_d = 32'h0; srcb_d = 32'h80000000;
      #1;
      chk("ne.equal", {31'd0, equal_d}, 32'd0);
      chk("ne.notequal", {31'd0, notequal_d}, 32'd1);
      srcb_d = 32'h0;
      #1;
      chk("ne.eq_notequal", {31'd0, notequal_d}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
